random_stream_sched: RTL and testbench

//  Shares one multi-stream Marsaglia RNG core (per-stream z/w state in BRAM) among NREQ requesters.

---
 rtl/random_sched_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/random_stream_sched.sv | 139 +++++++++++++
 tb/tb_random_stream_sched.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/random_sched_pkg.sv
// rtl/random_sched_pkg.sv - shared types and defaults for the random stream scheduler
package random_sched_pkg;

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      SETUP,
      WAIT,
      CAPTURE,
      GAPW
   } state_t;

   localparam int          DEF_SW     = 10;
   localparam logic [31:0] DEF_SEED_Z = 32'd17;
   localparam logic [31:0] DEF_SEED_W = 32'd3;
   localparam int          CNT_W      = 8;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts after the last grant
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx,
   output logic            valid
);

   logic [IW-1:0] k;

   always_comb begin
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      k     = '0;
      for (int i = 1; i <= NREQ; i++) begin
         k = IW'((int'(last) + i) % NREQ);
         if (!valid && req[k]) begin
            valid = 1'b1;
            idx   = k;
         end
      end
      if (valid) grant[idx] = 1'b1;
   end

endmodule

// File: rtl/random_stream_sched.sv
// rtl/random_stream_sched.sv - seeds every RNG stream, then serves requesters round-robin
module random_stream_sched
   import random_sched_pkg::*;
#(
   parameter int          NREQ   = 4,
   parameter int          SW     = DEF_SW,
   parameter int          LAT    = 2,
   parameter int          GAP    = 2,
   parameter logic [31:0] SEED_Z = DEF_SEED_Z,
   parameter logic [31:0] SEED_W = DEF_SEED_W
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NREQ-1:0]    req_i,
   input  logic [NREQ*SW-1:0] stream_i,
   output logic [NREQ-1:0]    ack_o,
   output logic [31:0]        dat_o,
   output logic               busy_o,
   output logic [SW-1:0]      core_stream_o,
   output logic               core_ld_o,
   output logic [31:0]        core_seedz_o,
   output logic [31:0]        core_seedw_o,
   output logic               core_next_o,
   input  logic [31:0]        core_dat_i
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t            state, state_nx;
   logic [SW-1:0]     init_cnt, stream_q;
   logic [CNT_W-1:0]  wait_cnt, gap_cnt;
   logic [IW-1:0]     rr_ptr, win_idx, arb_idx;
   logic [NREQ-1:0]   arb_grant, win_grant;
   logic              arb_valid;

   logic [NREQ-1:0]   ack_d;
   logic [31:0]       dat_d, seedz_d, seedw_d;
   logic [SW-1:0]     stream_d;
   logic              ld_d, next_d;

   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
      .req   (req_i),
      .last  (rr_ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= INIT;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         INIT:    if (init_cnt == {SW{1'b1}}) state_nx = GAPW;
         IDLE:    if (arb_valid) state_nx = SETUP;
         SETUP:   state_nx = WAIT;
         WAIT:    if (wait_cnt == '0) state_nx = CAPTURE;
         CAPTURE: state_nx = GAPW;
         GAPW:    if (gap_cnt == '0) state_nx = IDLE;
         default: state_nx = INIT;
      endcase
   end

   // Outputs are decoded here and registered below, so the core sees them one cycle after the state
   always_comb begin
      ack_d    = '0;
      dat_d    = '0;
      seedz_d  = '0;
      seedw_d  = '0;
      ld_d     = 1'b0;
      next_d   = 1'b0;
      stream_d = core_stream_o;
      unique case (state)
         INIT: begin
            stream_d = init_cnt;
            ld_d     = 1'b1;
            seedz_d  = SEED_Z + 32'(init_cnt);
            seedw_d  = SEED_W + 32'(init_cnt);
         end
         SETUP:   stream_d = stream_q;
         CAPTURE: begin
            ack_d  = win_grant;
            dat_d  = core_dat_i;
            next_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         init_cnt  <= '0;
         wait_cnt  <= '0;
         gap_cnt   <= '0;
         rr_ptr    <= IW'(NREQ - 1);
         win_idx   <= '0;
         win_grant <= '0;
         stream_q  <= '0;
      end else begin
         if (state == INIT && state_nx == INIT) init_cnt <= init_cnt + 1'b1;
         if (state == IDLE && arb_valid) begin
            win_idx   <= arb_idx;
            win_grant <= arb_grant;
            stream_q  <= stream_i[arb_idx*SW +: SW];
         end
         if (state == SETUP)     wait_cnt <= CNT_W'(LAT - 1);
         else if (state == WAIT) wait_cnt <= wait_cnt - 1'b1;
         if (state_nx == GAPW && state != GAPW) gap_cnt <= CNT_W'(GAP - 1);
         else if (state == GAPW)                gap_cnt <= gap_cnt - 1'b1;
         if (state == CAPTURE) rr_ptr <= win_idx;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ack_o         <= '0;
         dat_o         <= '0;
         core_stream_o <= '0;
         core_ld_o     <= 1'b0;
         core_seedz_o  <= '0;
         core_seedw_o  <= '0;
         core_next_o   <= 1'b0;
      end else begin
         ack_o         <= ack_d;
         dat_o         <= dat_d;
         core_stream_o <= stream_d;
         core_ld_o     <= ld_d;
         core_seedz_o  <= seedz_d;
         core_seedw_o  <= seedw_d;
         core_next_o   <= next_d;
      end
   end

   assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_random_stream_sched.sv
// tb/tb_random_stream_sched.sv - directed bench with a behavioural Marsaglia core
module tb_random_stream_sched;

   localparam int NREQ = 4;
   localparam int SW   = 10;
   localparam int LAT  = 2;
   localparam int GAP  = 2;

   logic               clk_i = 1'b0;
   logic               rst_i;
   logic [NREQ-1:0]    req_i;
   logic [NREQ*SW-1:0] stream_i;
   logic [NREQ-1:0]    ack_o;
   logic [31:0]        dat_o;
   logic               busy_o;
   logic [SW-1:0]      core_stream_o;
   logic               core_ld_o;
   logic [31:0]        core_seedz_o;
   logic [31:0]        core_seedw_o;
   logic               core_next_o;
   logic [31:0]        core_dat_i;

   always #5 clk_i = ~clk_i;

   random_stream_sched #(
      .NREQ(NREQ), .SW(SW), .LAT(LAT), .GAP(GAP),
      .SEED_Z(32'd17), .SEED_W(32'd3)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .req_i         (req_i),
      .stream_i      (stream_i),
      .ack_o         (ack_o),
      .dat_o         (dat_o),
      .busy_o        (busy_o),
      .core_stream_o (core_stream_o),
      .core_ld_o     (core_ld_o),
      .core_seedz_o  (core_seedz_o),
      .core_seedw_o  (core_seedw_o),
      .core_next_o   (core_next_o),
      .core_dat_i    (core_dat_i)
   );

   // Behavioural core: per-stream z/w in BRAM, two-stage registered read path
   logic [31:0] cz [0:1023];
   logic [31:0] cw [0:1023];
   logic [31:0] rd1;

   always @(posedge clk_i) begin
      if (core_ld_o) begin
         cz[core_stream_o] <= core_seedz_o;
         cw[core_stream_o] <= core_seedw_o;
      end else if (core_next_o) begin
         cz[core_stream_o] <= 36969 * (cz[core_stream_o] & 32'hFFFF) + (cz[core_stream_o] >> 16);
         cw[core_stream_o] <= 18000 * (cw[core_stream_o] & 32'hFFFF) + (cw[core_stream_o] >> 16);
      end
      rd1        <= (cz[core_stream_o] << 16) + cw[core_stream_o];
      core_dat_i <= rd1;
   end

   int checks = 0;
   int errors = 0;
   int both_cnt = 0;
   int ovl_cnt = 0;
   int next_cnt = 0;

   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (core_ld_o && core_next_o) both_cnt++;
         if (!$onehot0(ack_o)) ovl_cnt++;
         if (core_next_o) next_cnt++;
      end
   end

   function automatic logic [31:0] mval(input int s, input int n);
      logic [31:0] z, w;
      z = 32'd17 + s;
      w = 32'd3 + s;
      for (int i = 0; i < n; i++) begin
         z = 36969 * (z & 32'hFFFF) + (z >> 16);
         w = 18000 * (w & 32'hFFFF) + (w >> 16);
      end
      return (z << 16) + w;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic wait_ack(output int lat);
      int n;
      lat = -1;
      n = 0;
      while (lat < 0 && n < 60) begin
         @(negedge clk_i);
         n++;
         if (ack_o != '0) lat = n;
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy_o && n < 100) begin
         @(negedge clk_i);
         n++;
      end
   endtask

   task automatic run_init(output int nld, output int nbad, output int nack);
      int n;
      nld = 0; nbad = 0; nack = 0; n = 0;
      do begin
         @(negedge clk_i);
         n++;
         if (core_ld_o) begin
            if (core_stream_o != 10'(nld) || core_seedz_o != 32'd17 + nld ||
                core_seedw_o != 32'd3 + nld) nbad++;
            nld++;
         end
         if (ack_o != '0) nack++;
      end while (busy_o && n < 3000);
   endtask

   initial begin
      int lat, nld, nbad, nack, next0;
      rst_i = 1'b1;
      req_i = '0;
      stream_i = '0;
      repeat (3) @(negedge clk_i);
      chk("rst_busy",   32'(busy_o), 32'd1);
      chk("rst_ack",    32'(ack_o), 32'd0);
      chk("rst_dat",    dat_o, 32'd0);
      chk("rst_ld",     32'(core_ld_o), 32'd0);
      chk("rst_next",   32'(core_next_o), 32'd0);
      chk("rst_stream", 32'(core_stream_o), 32'd0);
      chk("rst_seedz",  core_seedz_o, 32'd0);
      rst_i = 1'b0;

      run_init(nld, nbad, nack);
      chk("init_ld_count", nld, 1024);
      chk("init_seed_bad", nbad, 0);
      chk("init_busy_low", 32'(busy_o), 32'd0);

      // All four held: rotation starts at requester 0 after reset
      stream_i = {10'd13, 10'd12, 10'd11, 10'd10};
      req_i = 4'b1111;
      next0 = next_cnt;
      for (int k = 0; k < 5; k++) begin
         wait_ack(lat);
         if (k == 0) chk("t3_latency", lat, LAT + 3);
         chk("t3_ack", 32'(ack_o), 32'(1 << (k % 4)));
         chk("t3_dat", dat_o, mval(10 + (k % 4), k / 4));
         if (k == 4) req_i = '0;
      end
      repeat (3) @(negedge clk_i);
      chk("t3_next_count", next_cnt - next0, 5);

      wait_idle();
      stream_i = '0;
      req_i = 4'b0001;
      wait_ack(lat);
      chk("t2_latency", lat, LAT + 3);
      chk("t2_ack", 32'(ack_o), 32'h1);
      chk("t2_dat", dat_o, 32'h00110003);
      req_i = '0;
      @(negedge clk_i);
      chk("t2_dat_clear", dat_o, 32'd0);
      chk("t2_ack_clear", 32'(ack_o), 32'd0);
      wait_idle();
      req_i = 4'b0001;
      wait_ack(lat);
      chk("t2_dat2", dat_o, 32'h96F9D2F0);
      req_i = '0;

      // Requesters 0 and 2 share stream 5; rr pointer sits at 0 so 2 goes first
      wait_idle();
      stream_i = {10'd0, 10'd5, 10'd0, 10'd5};
      req_i = 4'b0101;
      wait_ack(lat);
      chk("t4_ack_a", 32'(ack_o), 32'h4);
      chk("t4_dat_a", dat_o, 32'h00160008);
      req_i[2] = 1'b0;
      wait_ack(lat);
      chk("t4_ack_b", 32'(ack_o), 32'h1);
      chk("t4_dat_b", dat_o, 32'h69083280);
      req_i = '0;

      // Reset during WAIT abandons the service; requests held through INIT are served afterwards
      wait_idle();
      stream_i = {10'd0, 10'd0, 10'd9, 10'd7};
      req_i = 4'b0001;
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      chk("t6_ack",    32'(ack_o), 32'd0);
      chk("t6_dat",    dat_o, 32'd0);
      chk("t6_busy",   32'(busy_o), 32'd1);
      chk("t6_stream", 32'(core_stream_o), 32'd0);
      chk("t6_next",   32'(core_next_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      req_i = 4'b0011;
      run_init(nld, nbad, nack);
      chk("t6_ld_count", nld, 1024);
      chk("t6_seed_bad", nbad, 0);
      chk("t5_no_ack_init", nack, 0);
      wait_ack(lat);
      chk("t5_latency", lat, LAT + 3);
      chk("t5_ack_a", 32'(ack_o), 32'h1);
      chk("t5_dat_a", dat_o, 32'h0018000A);
      req_i[0] = 1'b0;
      wait_ack(lat);
      chk("t5_ack_b", 32'(ack_o), 32'h2);
      chk("t5_dat_b", dat_o, mval(9, 0));
      req_i = '0;

      repeat (3) @(negedge clk_i);
      chk("ld_next_overlap", both_cnt, 0);
      chk("ack_onehot", ovl_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
